rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 15 +
 rtl/rf_wr_fifo.sv | 97 +++++++++
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared defines for the register-file write arbiter: default sizing constants
// and the write-port source codes.
package rf_write_arbiter_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int DEPTH_DEFAULT        = 2;

  typedef enum logic [1:0] {
    RDSRC_NONE = 2'd0,
    RDSRC_PIPE = 2'd1,
    RDSRC_FIFO = 2'd2,
    RDSRC_MDU  = 2'd3
  } rdsrc_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Two-entry MDU result FIFO whose per-entry valid bits can be cleared
// by destination address when a younger pipeline write overtakes them.
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        kill_en,
  input  logic [4:0]  kill_rd,
  output logic        empty,
  output logic        full,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == FULL_COUNT);
  assign head_valid = valid_q[rd_ptr_q];
  assign head_rd    = rd_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];

  // Kill is applied first so a same-cycle push of a fresh entry is never cleared.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);

    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && (rd_q[i] == kill_rd)) begin
        valid_d[i] = 1'b0;
      end
    end

    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ~rd_ptr_q;
    end

    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = push_rd;
      data_d[wr_ptr_q]  = push_data;
      wr_ptr_d          = ~wr_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the writeback stage
// (always wins) and buffered multi-cycle-unit results.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int DEPTH        = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] rd_data_w,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req
);

  logic        pipe_eff;
  logic        mdu_accept;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        head_valid;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [2:0]  age_q, age_d;
  rdsrc_e      sel;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_rd    (mdu_rd),
    .push_data  (mdu_data),
    .pop        (pop),
    .kill_en    (pipe_eff),
    .kill_rd    (rd_w),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data)
  );

  assign mdu_ready = !fifo_full;
  assign stall_req = !fifo_empty && (int'(age_q) >= STARVE_LIMIT);

  // A result headed for x0, or one overtaken by a same-cycle pipeline write
  // to the same register, is accepted but never stored.
  always_comb begin
    pipe_eff   = rd_write_w && (rd_w != 5'd0);
    mdu_accept = mdu_valid && mdu_ready;
    sel        = RDSRC_NONE;
    if (pipe_eff) begin
      sel = RDSRC_PIPE;
    end else if (!fifo_empty) begin
      sel = RDSRC_FIFO;
    end else if (mdu_accept && (mdu_rd != 5'd0)) begin
      sel = RDSRC_MDU;
    end
    pop  = (sel == RDSRC_FIFO);
    push = mdu_accept && (sel != RDSRC_MDU) && (mdu_rd != 5'd0)
           && !(pipe_eff && (mdu_rd == rd_w));
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (sel)
      RDSRC_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = rd_w;
        rf_wdata = rd_data_w;
      end
      RDSRC_FIFO: begin
        rf_we    = head_valid;
        rf_waddr = head_rd;
        rf_wdata = head_data;
      end
      RDSRC_MDU: begin
        rf_we    = 1'b1;
        rf_waddr = mdu_rd;
        rf_wdata = mdu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (pop || fifo_empty) begin
      age_d = 3'd0;
    end else if (age_q != 3'd7) begin
      age_d = age_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= 3'd0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule
